stream_if_fifo: RTL and testbench
=================================

STREAM_IF_FIFO -- requirements
Module: stream_if_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits, legal values 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, a power of two, legal values 2..256.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1: almost_full asserts when count >= AF_THRESH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-007 SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-008 SHALL have port in_data, input, DATA_W bits: the producer payload.
REQ-009 SHALL have port in_ready, output, 1 bit: the FIFO accepts a word this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds the oldest stored word.
REQ-011 SHALL have port out_data, output, DATA_W bits: the consumer payload.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port almost_full, output, 1 bit: occupancy watermark flag.

Function
REQ-015 SHALL perform a push in a cycle where in_valid && in_ready, and a pop in a cycle where out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count != DEPTH), a pure function of registered state with no path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0), and out_data SHALL be the entry at the read pointer.
REQ-018 SHALL have a latency of 1 cycle: a word pushed at edge N is visible on out_data after edge N; there is no same-cycle fall-through.
REQ-019 SHALL hold the count unchanged on a simultaneous push and pop, with both pointers advancing.
REQ-020 SHALL refuse a push when full, even if a pop happens in the same cycle.
REQ-021 SHALL keep out_data stable while out_valid && !out_ready.
REQ-022 SHALL increment its pointers modulo DEPTH, so wrap-around is seamless and order is preserved across the wrap.
REQ-023 SHALL have flush zero the count and both pointers on the next edge; any push or pop in that cycle is ignored.
REQ-024 SHALL register almost_full, or derive it purely from count; it is never derived combinationally from the inputs.
REQ-025 SHALL hold all payload and pointers unchanged when in_valid is asserted without in_ready, because no transfer occurs.

Reset
REQ-026 SHALL, while rst is high at a rising edge, zero the count and both pointers, giving in_ready=1, out_valid=0, almost_full=0 and count=0.
REQ-027 SHALL leave the storage array contents unreset, with out_data a don't-care while out_valid=0.
REQ-028 SHALL give rst priority over flush, push and pop, and a rst asserted mid-stream SHALL discard all stored entries.

Configuration
REQ-029 SHALL, with macro STREAM_IF_FIFO_STATS_EN defined, add output hi_water of $clog2(DEPTH)+1 bits.
REQ-030 SHALL make hi_water hold the maximum count reached since the last rst, cleared by rst only and not by flush.
REQ-031 SHALL add output ovf_attempt, 1 bit, under the same macro, pulsing for one cycle when in_valid && !in_ready.
REQ-032 SHALL, with STREAM_IF_FIFO_STATS_EN undefined, have neither hi_water nor ovf_attempt as ports and contain no statistics logic.

Structure
REQ-033 SHALL take its shared constants and helper functions from package stream_if_pkg: a pointer-width function, the default DATA_W/DEPTH, and the count typedef.
REQ-034 SHALL place the storage in one sub-module, stream_if_ram: a DEPTH x DATA_W array with one write port and one asynchronous read port.
REQ-035 SHALL keep pointers, count and handshake logic in stream_if_fifo itself.

Verification
REQ-036 SHALL pass fill/drain: DEPTH=4, push AA, BB, CC, DD with out_ready=0 -> count=4, in_ready=0, almost_full=1; then out_ready=1 -> out_data AA, BB, CC, DD in order, one per cycle, ending with count=0 and out_valid=0.
REQ-037 SHALL pass wrap-around: push and pop continuously for 10 words 00..09 -> output sequence 00..09 with no gaps after the first, and count constant at 1.
REQ-038 SHALL pass backpressure: full FIFO with in_valid=1, data 55, out_ready=0 for 3 cycles -> no push, out_data stable, and ovf_attempt high for 3 cycles when STATS_EN is defined.
REQ-039 SHALL pass full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3 the next cycle.
REQ-040 SHALL pass flush and reset: with count=3, flush=1 together with push -> count=0 and hi_water still 3; then rst=1 mid-stream -> count=0, out_valid=0, hi_water=0.
REQ-041 SHALL pass a parameter sweep: DATA_W=32, DEPTH=16, AF_THRESH=12 -> almost_full rises on the edge where count becomes 12 and falls when count becomes 11.

Source files
------------

// File: rtl/stream_if_pkg.sv
// -----------------------------------------------------------------------------
// stream_if_pkg
//   Shared constants and helpers for the stream_if FIFO slice.
//   - DEFAULT_DATA_W / DEFAULT_DEPTH : default payload width and entry count
//   - ptr_w()                        : read/write pointer width for a depth
//   - count_t                        : occupancy type for the default depth
// -----------------------------------------------------------------------------
package stream_if_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  // Pointer width for a power-of-two depth. Never narrower than one bit, so
  // a two-entry FIFO still has a real pointer to toggle.
  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one more bit than the pointers, so that "full" (DEPTH)
  // and "empty" (0) are distinct values.
  localparam int DEFAULT_CNT_W = ptr_w(DEFAULT_DEPTH) + 1;

  typedef logic [DEFAULT_CNT_W-1:0] count_t;

endpackage

// File: rtl/stream_if_ram.sv
// -----------------------------------------------------------------------------
// stream_if_ram
//   DEPTH x DATA_W storage for the stream FIFO: one synchronous write port,
//   one asynchronous (combinational) read port.
//   Ports:
//     clk    - write clock
//     we     - write enable, writes wdata to mem[waddr] on the rising edge
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address
//     rdata  - mem[raddr], combinational
// -----------------------------------------------------------------------------
module stream_if_ram
  import stream_if_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; occupancy lives in the
  // FIFO's count, so stale contents are never presented as valid, and an
  // unreset array maps onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_if_fifo.sv
// -----------------------------------------------------------------------------
// stream_if_fifo
//   Synchronous valid/ready FIFO with one cycle of latency (no fall-through).
//   in_ready depends only on registered occupancy, so there is no
//   combinational path from out_ready back to in_ready.
//
//   Ports:
//     clk         - single clock, rising edge
//     rst         - synchronous, active-high reset (priority over everything)
//     flush       - synchronous discard of all stored entries
//     in_valid    - producer offers in_data
//     in_data     - producer payload
//     in_ready    - FIFO accepts a word this cycle (count != DEPTH)
//     out_valid   - out_data holds the oldest stored word (count != 0)
//     out_data    - consumer payload
//     out_ready   - consumer takes out_data this cycle
//     count       - current occupancy, 0..DEPTH
//     almost_full - count >= AF_THRESH
//
//   Optional statistics, built when STREAM_IF_FIFO_STATS_EN is defined:
//     hi_water    - highest occupancy since the last rst (flush keeps it)
//     ovf_attempt - high in any cycle where in_valid is refused (FIFO full)
// -----------------------------------------------------------------------------
module stream_if_fifo
  import stream_if_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full
`ifdef STREAM_IF_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]  hi_water,
  output logic                    ovf_attempt
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  // A threshold above DEPTH can never be reached; keep it from truncating
  // into a small value that would assert early.
  localparam bit               AF_NEVER = (AF_THRESH > DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push, pop;
  logic             wr_en;

  // ---------------------------------------------------------------------------
  // Handshake: both sides look only at registered occupancy.
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  // ---------------------------------------------------------------------------
  assign in_ready    = (count_q != FULL_CNT);
  assign out_valid   = (count_q != '0);
  assign push        = in_valid  & in_ready;
  assign pop         = out_valid & out_ready;
  assign count       = count_q;
  assign almost_full = !AF_NEVER && (count_q >= AF_CNT);

  // ---------------------------------------------------------------------------
  // Next-state for pointers and occupancy. Pointers are PTR_W bits wide and
  // DEPTH is a power of two, so the +1 wraps modulo DEPTH by itself.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given its hold value first, so no
  // path through the branches leaves a signal unassigned and no latch forms.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      // Flush wins over any push or pop offered in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;  // idle, or push+pop: occupancy holds
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. The write is suppressed under rst/flush so an ignored push does
  // not disturb the array either. Asynchronous read of the read pointer gives
  // a word on out_data one edge after it was pushed, and holds it steady
  // while the consumer stalls because rd_ptr does not move.
  // ---------------------------------------------------------------------------
  assign wr_en = push & ~flush & ~rst;

  stream_if_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

`ifdef STREAM_IF_FIFO_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics. hi_water tracks the next occupancy so that it moves on the
  // same edge as count. Only rst clears it; a flush is part of normal
  // operation and must not hide the peak that preceded it.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hi_water_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_water_q <= '0;
    end else if (count_d > hi_water_q) begin
      hi_water_q <= count_d;
    end
  end

  assign hi_water    = hi_water_q;
  assign ovf_attempt = in_valid & ~in_ready;
`endif

endmodule

// File: tb/tb_stream_if_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_if_fifo
//   Self-checking bench for stream_if_fifo.
//   dut_a : default parameters (DATA_W=8, DEPTH=4, AF_THRESH=3)
//   dut_b : DATA_W=32, DEPTH=16, AF_THRESH=12
//   Each DUT is shadowed by a queue model; directed rows also carry their own
//   hand-derived expected values. Statistics outputs are checked when
//   STREAM_IF_FIFO_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_if_fifo;
  import stream_if_pkg::*;

  localparam int DEPTH_A = 4;
  localparam int AF_A    = 3;
  localparam int DEPTH_B = 16;
  localparam int AF_B    = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- dut_a ----------------
  logic        rst_a = 1'b1, flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [7:0]  in_data_a = '0, out_data_a;
  logic        in_ready_a, out_valid_a, af_a;
  count_t      count_a;
`ifdef STREAM_IF_FIFO_STATS_EN
  count_t      hi_a;
  logic        ovf_a;
`endif

  stream_if_fifo dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .flush       (flush_a),
    .in_valid    (in_valid_a),
    .in_data     (in_data_a),
    .in_ready    (in_ready_a),
    .out_valid   (out_valid_a),
    .out_data    (out_data_a),
    .out_ready   (out_ready_a),
    .count       (count_a),
    .almost_full (af_a)
`ifdef STREAM_IF_FIFO_STATS_EN
    ,
    .hi_water    (hi_a),
    .ovf_attempt (ovf_a)
`endif
  );

  // ---------------- dut_b ----------------
  logic        rst_b = 1'b1, flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [31:0] in_data_b = '0, out_data_b;
  logic        in_ready_b, out_valid_b, af_b;
  logic [4:0]  count_b;
`ifdef STREAM_IF_FIFO_STATS_EN
  logic [4:0]  hi_b;
  logic        ovf_b;
`endif

  stream_if_fifo #(
    .DATA_W    (32),
    .DEPTH     (DEPTH_B),
    .AF_THRESH (AF_B)
  ) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .flush       (flush_b),
    .in_valid    (in_valid_b),
    .in_data     (in_data_b),
    .in_ready    (in_ready_b),
    .out_valid   (out_valid_b),
    .out_data    (out_data_b),
    .out_ready   (out_ready_b),
    .count       (count_b),
    .almost_full (af_b)
`ifdef STREAM_IF_FIFO_STATS_EN
    ,
    .hi_water    (hi_b),
    .ovf_attempt (ovf_b)
`endif
  );

  // ---------------- reference models ----------------
  logic [7:0]  qa[$];
  logic [31:0] qb[$];
  int          hw_a = 0;
  int          hw_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model_a();
    check("a_count",       64'(count_a),     64'(qa.size()));
    check("a_out_valid",   64'(out_valid_a), 64'(qa.size() != 0));
    check("a_in_ready",    64'(in_ready_a),  64'(qa.size() != DEPTH_A));
    check("a_almost_full", 64'(af_a),        64'(qa.size() >= AF_A));
    if (qa.size() != 0) check("a_out_data", 64'(out_data_a), 64'(qa[0]));
`ifdef STREAM_IF_FIFO_STATS_EN
    check("a_hi_water",    64'(hi_a),        64'(hw_a));
`endif
  endtask

  task automatic check_model_b();
    check("b_count",       64'(count_b),     64'(qb.size()));
    check("b_out_valid",   64'(out_valid_b), 64'(qb.size() != 0));
    check("b_in_ready",    64'(in_ready_b),  64'(qb.size() != DEPTH_B));
    check("b_almost_full", 64'(af_b),        64'(qb.size() >= AF_B));
    if (qb.size() != 0) check("b_out_data", 64'(out_data_b), 64'(qb[0]));
`ifdef STREAM_IF_FIFO_STATS_EN
    check("b_hi_water",    64'(hi_b),        64'(hw_b));
`endif
  endtask

  // One clock cycle on dut_a: drive, update the model, cross the edge, check.
  // Called at posedge+1; samples #1 after the next posedge.
  task automatic cycle_a(input bit r, input bit f, input bit iv, input logic [7:0] d, input bit ordy);
    int  sz;
    bit  do_push, do_pop;
    rst_a = r; flush_a = f; in_valid_a = iv; in_data_a = d; out_ready_a = ordy;
    #1;
    sz      = qa.size();
    do_push = iv && (sz != DEPTH_A);
    do_pop  = ordy && (sz != 0);
`ifdef STREAM_IF_FIFO_STATS_EN
    check("a_ovf_attempt", 64'(ovf_a), 64'(iv && (sz == DEPTH_A)));
`endif
    if (r) begin
      qa.delete();
      hw_a = 0;
    end else if (f) begin
      qa.delete();
    end else begin
      if (do_pop)  void'(qa.pop_front());
      if (do_push) qa.push_back(d);
      if (qa.size() > hw_a) hw_a = qa.size();
    end
    @(posedge clk);
    #1;
    check_model_a();
  endtask

  task automatic cycle_b(input bit r, input bit f, input bit iv, input logic [31:0] d, input bit ordy);
    int  sz;
    bit  do_push, do_pop;
    rst_b = r; flush_b = f; in_valid_b = iv; in_data_b = d; out_ready_b = ordy;
    #1;
    sz      = qb.size();
    do_push = iv && (sz != DEPTH_B);
    do_pop  = ordy && (sz != 0);
`ifdef STREAM_IF_FIFO_STATS_EN
    check("b_ovf_attempt", 64'(ovf_b), 64'(iv && (sz == DEPTH_B)));
`endif
    if (r) begin
      qb.delete();
      hw_b = 0;
    end else if (f) begin
      qb.delete();
    end else begin
      if (do_pop)  void'(qb.pop_front());
      if (do_push) qb.push_back(d);
      if (qb.size() > hw_b) hw_b = qb.size();
    end
    @(posedge clk);
    #1;
    check_model_b();
  endtask

  // Directed vectors for dut_a: inputs for one cycle, then the state expected
  // after that cycle's edge (e_data only meaningful when e_ov is set).
  typedef struct {
    bit         r, f, iv;
    logic [7:0] d;
    bit         ordy;
    int         e_cnt;
    bit         e_ov, e_ir, e_af;
    logic [7:0] e_data;
    int         e_hw;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] w;

    //        r  f  iv d      ordy  cnt ov ir af data   hw
    tbl[0]  = '{1, 0, 0, 8'h00, 0,  0,  0, 1, 0, 8'h00, 0};  // reset state
    tbl[1]  = '{0, 0, 1, 8'hAA, 0,  1,  1, 1, 0, 8'hAA, 1};  // fill
    tbl[2]  = '{0, 0, 1, 8'hBB, 0,  2,  1, 1, 0, 8'hAA, 2};
    tbl[3]  = '{0, 0, 1, 8'hCC, 0,  3,  1, 1, 1, 8'hAA, 3};
    tbl[4]  = '{0, 0, 1, 8'hDD, 0,  4,  1, 0, 1, 8'hAA, 4};  // full
    tbl[5]  = '{0, 0, 1, 8'h55, 0,  4,  1, 0, 1, 8'hAA, 4};  // backpressure x3
    tbl[6]  = '{0, 0, 1, 8'h55, 0,  4,  1, 0, 1, 8'hAA, 4};
    tbl[7]  = '{0, 0, 1, 8'h55, 0,  4,  1, 0, 1, 8'hAA, 4};
    tbl[8]  = '{0, 0, 1, 8'hEE, 1,  3,  1, 1, 1, 8'hBB, 4};  // full + pop: pop only
    tbl[9]  = '{0, 0, 0, 8'h00, 1,  2,  1, 1, 0, 8'hCC, 4};  // drain
    tbl[10] = '{0, 0, 0, 8'h00, 1,  1,  1, 1, 0, 8'hDD, 4};
    tbl[11] = '{0, 0, 0, 8'h00, 1,  0,  0, 1, 0, 8'h00, 4};
    tbl[12] = '{1, 0, 0, 8'h00, 0,  0,  0, 1, 0, 8'h00, 0};
    tbl[13] = '{0, 0, 1, 8'h11, 0,  1,  1, 1, 0, 8'h11, 1};
    tbl[14] = '{0, 0, 1, 8'h22, 0,  2,  1, 1, 0, 8'h11, 2};
    tbl[15] = '{0, 0, 1, 8'h33, 0,  3,  1, 1, 1, 8'h11, 3};
    tbl[16] = '{0, 1, 1, 8'h44, 1,  0,  0, 1, 0, 8'h00, 3};  // flush beats push/pop
    tbl[17] = '{0, 0, 1, 8'h66, 0,  1,  1, 1, 0, 8'h66, 3};
    tbl[18] = '{0, 0, 1, 8'h77, 0,  2,  1, 1, 0, 8'h66, 3};
    tbl[19] = '{1, 0, 1, 8'h88, 1,  0,  0, 1, 0, 8'h00, 0};  // rst mid-stream

    @(posedge clk);
    #1;

    // ---- directed table on dut_a ----
    for (int i = 0; i < NVEC; i++) begin
      cycle_a(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check($sformatf("vec%0d_count", i),       64'(count_a),     64'(tbl[i].e_cnt));
      check($sformatf("vec%0d_out_valid", i),   64'(out_valid_a), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_in_ready", i),    64'(in_ready_a),  64'(tbl[i].e_ir));
      check($sformatf("vec%0d_almost_full", i), 64'(af_a),        64'(tbl[i].e_af));
      if (tbl[i].e_ov) check($sformatf("vec%0d_out_data", i), 64'(out_data_a), 64'(tbl[i].e_data));
`ifdef STREAM_IF_FIFO_STATS_EN
      check($sformatf("vec%0d_hi_water", i),    64'(hi_a),        64'(tbl[i].e_hw));
`endif
    end

    // ---- wrap-around: continuous push+pop of 00..09 ----
    cycle_a(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      cycle_a(0, 0, 1, 8'(i), 1);
      check("wrap_count", 64'(count_a),    64'd1);
      check("wrap_data",  64'(out_data_a), 64'(i));
    end
    cycle_a(0, 0, 0, 8'h00, 1);
    check("wrap_drained", 64'(out_valid_a), 64'd0);

    // ---- randomized traffic on dut_a against the queue model ----
    for (int i = 0; i < 600; i++) begin
      cycle_a(($urandom_range(63) == 0), ($urandom_range(31) == 0),
              ($urandom_range(3) != 0), 8'($urandom), $urandom_range(1) == 1);
    end

    // ---- parameter sweep on dut_b: almost_full edges at 12 ----
    cycle_b(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH_B; i++) begin
      w = $urandom;
      cycle_b(0, 0, 1, w, 0);
      check("b_af_rise", 64'(af_b), 64'((i + 1) >= 12));
    end
    cycle_b(0, 0, 1, 32'hDEAD_BEEF, 0);           // refused while full
    check("b_full_hold", 64'(count_b), 64'd16);
    for (int i = 0; i < DEPTH_B; i++) begin
      cycle_b(0, 0, 0, 32'h0, 1);
      check("b_af_fall", 64'(af_b), 64'((15 - i) >= 12));
    end
    for (int i = 0; i < 300; i++) begin
      cycle_b(($urandom_range(63) == 0), ($urandom_range(31) == 0),
              ($urandom_range(3) != 0), $urandom, $urandom_range(3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
